// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: runs one 8-bit ALU op through a 4-bit core chain
// in two nibble phases (low, then high) and assembles Z80 flags.
module alu_nibble_seq (
    input  logic       clk,
    input  logic       nreset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       use_cy,
    input  logic       cf_in,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [3:0] core_op1,
    output logic [3:0] core_op2,
    output logic       core_cy_in,
    output logic       core_R,
    output logic       core_S,
    output logic       core_V,
    input  logic [3:0] core_result,
    input  logic       core_cy_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       sf,
    output logic       zf,
    output logic       hf,
    output logic       pvf,
    output logic       cf
);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_XOR = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2
    } state_t;

    state_t     state_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [1:0] op_q;
    logic       cin0_q;
    logic       hcy_q;
    logic [3:0] lo_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] result_q;
    logic       sf_q;
    logic       zf_q;
    logic       hf_q;
    logic       pvf_q;
    logic       cf_q;

    logic [7:0] res_d;
    logic       sf_d;
    logic       zf_d;
    logic       hf_d;
    logic       pvf_d;
    logic       cf_d;

    logic [3:0] op1_d;
    logic [3:0] op2_d;
    logic       cy_d;
    logic       r_d;
    logic       s_d;
    logic       v_d;

    // Core chain drive: nibble select by phase, controls from latched op.
    always_comb begin
        op1_d = 4'h0;
        op2_d = 4'h0;
        cy_d  = 1'b0;
        r_d   = 1'b0;
        s_d   = 1'b0;
        v_d   = 1'b0;
        if (state_q == S_LO || state_q == S_HI) begin
            if (state_q == S_LO) begin
                op1_d = a_q[3:0];
                op2_d = b_q[3:0];
            end else begin
                op1_d = a_q[7:4];
                op2_d = b_q[7:4];
            end
            case (op_q)
                OP_ADD: begin
                    cy_d = (state_q == S_LO) ? cin0_q : hcy_q;
                end
                OP_XOR: begin
                    r_d = 1'b1;
                end
                OP_AND: begin
                    s_d  = 1'b1;
                    cy_d = 1'b1;
                end
                OP_OR: begin
                    r_d = 1'b1;
                    s_d = 1'b1;
                    v_d = 1'b1;
                end
                default: begin
                    cy_d = 1'b0;
                end
            endcase
        end
    end

    // Final result and flags, valid while in the high-nibble phase.
    always_comb begin
        res_d = {core_result, lo_q};
        sf_d  = res_d[7];
        zf_d  = (res_d == 8'h00);
        hf_d  = 1'b0;
        cf_d  = 1'b0;
        pvf_d = ~^res_d;
        case (op_q)
            OP_ADD: begin
                hf_d  = hcy_q;
                cf_d  = core_cy_out;
                pvf_d = (a_q[7] == b_q[7]) && (res_d[7] != a_q[7]);
            end
            OP_AND: begin
                hf_d = 1'b1;
            end
            default: begin
                hf_d = 1'b0;
            end
        endcase
    end

    // Sequencer: capture, low phase, high phase, publish.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q  <= S_IDLE;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            op_q     <= OP_ADD;
            cin0_q   <= 1'b0;
            hcy_q    <= 1'b0;
            lo_q     <= 4'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 8'h00;
            sf_q     <= 1'b0;
            zf_q     <= 1'b0;
            hf_q     <= 1'b0;
            pvf_q    <= 1'b0;
            cf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        cin0_q  <= (op == OP_ADD) & use_cy & cf_in;
                        busy_q  <= 1'b1;
                        state_q <= S_LO;
                    end
                end
                S_LO: begin
                    lo_q    <= core_result;
                    hcy_q   <= core_cy_out;
                    state_q <= S_HI;
                end
                S_HI: begin
                    result_q <= res_d;
                    sf_q     <= sf_d;
                    zf_q     <= zf_d;
                    hf_q     <= hf_d;
                    pvf_q    <= pvf_d;
                    cf_q     <= cf_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign core_op1   = op1_d;
    assign core_op2   = op2_d;
    assign core_cy_in = cy_d;
    assign core_R     = r_d;
    assign core_S     = s_d;
    assign core_V     = v_d;
    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign sf         = sf_q;
    assign zf         = zf_q;
    assign hf         = hf_q;
    assign pvf        = pvf_q;
    assign cf         = cf_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb_alu_nibble_seq: scoreboard bench with a behavioural 4-bit core
// chain model wired in place of the external slices.
module tb_alu_nibble_seq;

    logic       clk = 1'b0;
    logic       nreset;
    logic       start;
    logic [1:0] op;
    logic       use_cy;
    logic       cf_in;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] core_op1;
    logic [3:0] core_op2;
    logic       core_cy_in;
    logic       core_R;
    logic       core_S;
    logic       core_V;
    logic [3:0] core_result;
    logic       core_cy_out;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       sf;
    logic       zf;
    logic       hf;
    logic       pvf;
    logic       cf;

    int nchecks = 0;
    int nerrors = 0;
    int cyc = 0;

    typedef struct {
        logic [12:0] v;
        int          cyc;
    } exp_t;

    exp_t exq[$];

    alu_nibble_seq dut (
        .clk(clk), .nreset(nreset), .start(start), .op(op),
        .use_cy(use_cy), .cf_in(cf_in), .a(a), .b(b),
        .core_op1(core_op1), .core_op2(core_op2),
        .core_cy_in(core_cy_in), .core_R(core_R), .core_S(core_S),
        .core_V(core_V), .core_result(core_result),
        .core_cy_out(core_cy_out), .busy(busy), .done(done),
        .result(result), .sf(sf), .zf(zf), .hf(hf), .pvf(pvf), .cf(cf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Core chain stand-in: controls select add / xor / and / or.
    always_comb begin
        core_result = 4'h0;
        core_cy_out = 1'b0;
        case ({core_R, core_S, core_V})
            3'b000: {core_cy_out, core_result} =
                {1'b0, core_op1} + {1'b0, core_op2} + {4'h0, core_cy_in};
            3'b100: core_result = core_op1 ^ core_op2;
            3'b010: core_result = core_op1 & core_op2;
            3'b111: core_result = core_op1 | core_op2;
            default: core_result = 4'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchecks++;
        if (obs !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference 8-bit ALU: {result, S, Z, H, P/V, C}.
    function automatic logic [12:0] ref_alu(input logic [1:0] o,
        input logic uc, input logic ci, input logic [7:0] x,
        input logic [7:0] y);
        logic [8:0] s;
        logic [4:0] hs;
        logic [7:0] r;
        logic       h;
        logic       p;
        logic       c;
        logic       cin;
        cin = (o == 2'd0) & uc & ci;
        s   = {1'b0, x} + {1'b0, y} + {8'h00, cin};
        hs  = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'h0, cin};
        r = 8'h00; h = 1'b0; p = 1'b0; c = 1'b0;
        case (o)
            2'd0: begin
                r = s[7:0];
                c = s[8];
                h = hs[4];
                p = (x[7] == y[7]) && (r[7] != x[7]);
            end
            2'd1: begin r = x ^ y; p = ~^r; end
            2'd2: begin r = x & y; p = ~^r; h = 1'b1; end
            default: begin r = x | y; p = ~^r; end
        endcase
        return {r, r[7], r == 8'h00, h, p, c};
    endfunction

    // Scoreboard: compare each completion against the oldest request.
    always @(negedge clk) begin
        if (nreset && done) begin
            if (exq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exq.pop_front();
                chk("result", {24'h0, result}, {24'h0, e.v[12:5]});
                chk("flags", {27'h0, sf, zf, hf, pvf, cf},
                    {27'h0, e.v[4:0]});
                chk("latency", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; returns one negedge later with start low.
    task automatic drive(input logic [1:0] o, input logic uc,
        input logic ci, input logic [7:0] x, input logic [7:0] y,
        input bit accept);
        exp_t e;
        op = o; use_cy = uc; cf_in = ci; a = x; b = y;
        start = 1'b1;
        if (accept) begin
            e.v   = ref_alu(o, uc, ci, x, y);
            e.cyc = cyc + 3;
            exq.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset = 1'b0; start = 1'b0; op = 2'd0; use_cy = 1'b0;
        cf_in = 1'b0; a = 8'h00; b = 8'h00;
        idle(3);
        nreset = 1'b1;
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_result", {24'h0, result}, 32'd0);
        chk("rst_core", {20'h0, core_op1, core_op2, core_cy_in,
            core_R, core_S, core_V}, 32'd0);

        drive(2'd0, 1'b0, 1'b0, 8'h3B, 8'h45, 1'b1);
        chk("add_lo_busy", {31'h0, busy}, 32'd1);
        chk("add_lo_ops", {24'h0, core_op1, core_op2}, 32'hB5);
        chk("add_lo_cy", {31'h0, core_cy_in}, 32'd0);
        chk("add_rsv", {29'h0, core_R, core_S, core_V}, 32'd0);
        idle(1);
        chk("add_hi_cy", {31'h0, core_cy_in}, 32'd1);
        chk("add_hi_ops", {24'h0, core_op1, core_op2}, 32'h34);
        idle(2);

        drive(2'd0, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b1);
        idle(3);

        drive(2'd2, 1'b0, 1'b0, 8'h6C, 8'h35, 1'b1);
        chk("and_lo_cy", {31'h0, core_cy_in}, 32'd1);
        chk("and_rsv", {29'h0, core_R, core_S, core_V}, 32'b010);
        idle(1);
        chk("and_hi_cy", {31'h0, core_cy_in}, 32'd1);
        idle(2);

        drive(2'd1, 1'b0, 1'b0, 8'hAA, 8'hAA, 1'b1);
        chk("xor_rsv", {29'h0, core_R, core_S, core_V}, 32'b100);
        idle(3);
        drive(2'd3, 1'b0, 1'b0, 8'h01, 8'h02, 1'b1);
        chk("or_rsv", {29'h0, core_R, core_S, core_V}, 32'b111);
        idle(3);

        // Start during LO ignored; inputs change mid-operation.
        drive(2'd0, 1'b0, 1'b0, 8'h12, 8'h34, 1'b1);
        drive(2'd3, 1'b0, 1'b0, 8'hF0, 8'h0F, 1'b0);
        a = 8'h99; b = 8'h77; op = 2'd2;
        idle(1);
        // Now in the done cycle: a new start is accepted.
        drive(2'd1, 1'b0, 1'b0, 8'h5A, 8'h3C, 1'b1);
        idle(3);

        // Reset while in HI aborts without a done.
        drive(2'd0, 1'b0, 1'b0, 8'h11, 8'h22, 1'b1);
        idle(1);
        chk("pre_abort_busy", {31'h0, busy}, 32'd1);
        nreset = 1'b0;
        exq.delete();
        idle(1);
        nreset = 1'b1;
        chk("abort_busy", {31'h0, busy}, 32'd0);
        chk("abort_done", {31'h0, done}, 32'd0);
        chk("abort_result", {24'h0, result}, 32'd0);
        chk("abort_flags", {27'h0, sf, zf, hf, pvf, cf}, 32'd0);
        chk("abort_core", {20'h0, core_op1, core_op2, core_cy_in,
            core_R, core_S, core_V}, 32'd0);
        idle(5);

        // Back-to-back random operations.
        for (int i = 0; i < 40; i++) begin
            drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                1'b1);
            idle(2);
        end
        idle(4);
        chk("pending", exq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
            nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/alu_nibble_seq.md
Name: alu_nibble_seq

Overview:
- Sequences one 8-bit ALU operation through the external 4-bit, four-slice ALU core chain in two phases: low nibble first, then high nibble.
- Captures the operands and drives the chain's op1/op2/cy_in and R/S/V controls.
- Latches the nibble carry between the two phases.
- Assembles the 8-bit result and the Z80 flags (S, Z, H, P/V, C).
- Sits directly upstream of the core chain, feeding it, and consumes the chain's result and carry.

Parameters:
- None. The datapath is fixed at 8 bits over a 4-bit core chain.

Ports:
- clk  in  1  clock, rising-edge.
- nreset  in  1  synchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation: 0=ADD, 1=XOR, 2=AND, 3=OR.
- use_cy  in  1  ADD only: 1 selects ADC (carry in = cf_in).
- cf_in  in  1  incoming carry flag.
- a  in  8  operand 1.
- b  in  8  operand 2.
- core_op1  out  4  nibble to core op1.
- core_op2  out  4  nibble to core op2.
- core_cy_in  out  1  carry into the core chain LSB slice.
- core_R  out  1  core control R.
- core_S  out  1  core control S.
- core_V  out  1  core control V.
- core_result  in  4  combinational result from the core chain.
- core_cy_out  in  1  carry out of the core chain MSB slice.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- result  out  8  final result.
- sf  out  1  sign flag.
- zf  out  1  zero flag.
- hf  out  1  half-carry flag.
- pvf  out  1  parity/overflow flag.
- cf  out  1  carry flag.

Behaviour:
- Reset (nreset=0 at a rising edge):
  - state=IDLE.
  - busy=0, done=0, result=0x00, all flags=0.
  - Latched operands, op, carry and low nibble are cleared.
  - Reset applies in any state, including mid-operation. No done is produced for an aborted operation.
- States: IDLE -> LO -> HI -> IDLE.
- IDLE, start=1 at edge k:
  - Capture a, b, op, and cin0, where cin0 = use_cy&cf_in for ADD.
  - busy=1, state=LO.
  - If start=0, remain in IDLE. done is cleared on any edge where it was 1.
- Control encoding, held constant through LO and HI:
  - ADD: R=0, S=0, V=0.
  - XOR: R=1, S=0, V=0.
  - AND: R=0, S=1, V=0.
  - OR: R=1, S=1, V=1.
- Carry into the chain:
  - LO phase: ADD drives cin0; XOR drives 0; AND drives 1; OR drives 0.
  - HI phase: ADD drives the latched nibble carry; logic ops drive the same constant as in LO.
- LO state:
  - core_op1=a[3:0], core_op2=b[3:0].
  - At edge k+1: latch core_result as lo_res and core_cy_out as hcy, then state=HI.
- HI state:
  - core_op1=a[7:4], core_op2=b[7:4].
  - At edge k+2: result={core_result, lo_res}, flags update, done=1, busy=0, state=IDLE.
- IDLE core outputs: all core_* outputs are driven 0.
- Latency: done is high during the cycle after edge k+2, i.e. 2 clocks after start is sampled. Throughput is one operation per 3 clocks.
- Flags, computed from the final 8-bit result r:
  - sf=r[7]; zf=(r==0).
  - ADD: hf=hcy; cf=core_cy_out in HI; pvf=(a[7]==b[7]) && (r[7]!=a[7]).
  - AND: hf=1, cf=0, pvf=even parity of r.
  - XOR/OR: hf=0, cf=0, pvf=even parity of r.
- result and flags hold until the next completion or reset.
- start while busy=1 is ignored: no queueing, and the captured operands are unaffected.
- start=1 in the cycle done=1 (state is IDLE) is accepted. Back-to-back operations are legal.
- Operand or op changes on the inputs after capture have no effect on the operation in progress.

Test Plan:
- ADD a=0x3B, b=0x45, use_cy=0 -> done 2 clocks after start; result=0x80, sf=1, zf=0, hf=1, pvf=1, cf=0. During LO: core_op1=0xB, core_op2=0x5, core_cy_in=0. During HI: core_cy_in=1.
- ADC a=0xFF, b=0x00, use_cy=1, cf_in=1 -> result=0x00, zf=1, hf=1, cf=1, pvf=0, sf=0.
- AND 0x6C & 0x35 -> result=0x24, hf=1, pvf=1, cf=0, core_cy_in=1, R/S/V=0/1/0. XOR 0xAA ^ 0xAA -> 0x00, zf=1, pvf=1, hf=0. OR 0x01 | 0x02 -> 0x03, pvf=1.
- Second start pulsed during LO with different operands -> ignored; the first result completes unchanged. A new start in the done cycle -> accepted; the next done follows 2 clocks later.
- nreset=0 at an edge while in HI -> next cycle busy=0, done=0, result=0x00, flags=0, core_* outputs=0; no later done pulse for the aborted operation.
- Operands change at edge k+1 (mid-operation) -> result reflects the values captured at edge k.
